// File: rtl/fout_period_meter.sv
`default_nettype none
// ============================================================================
// Module      : fout_period_meter
// Description : Measures the period and high time of an asynchronous square
//               wave `fin` in `clk` cycles, one result per `start` request.
//               Optional macro CONTINUOUS_MEAS_EN switches to free-running
//               back-to-back measurement (start ignored).
// Revision    : 1.0 - initial release
// ============================================================================
module fout_period_meter #(
    parameter int CNT_W       = 24,
    parameter int TIMEOUT_CYC = 1000000,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fin,
    input  logic             start,
    output logic             busy,
    output logic             valid,
    output logic             timeout,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARM     = 2'd1,
        ST_MEASURE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_timeout = CNT_W'(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] c_one     = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_zero    = '0;

`ifdef CONTINUOUS_MEAS_EN
    // Free-running: come out of reset already armed and report busy.
    localparam state_t c_rst_state = ST_ARM;
    localparam logic   c_rst_busy  = 1'b1;
`else
    localparam state_t c_rst_state = ST_IDLE;
    localparam logic   c_rst_busy  = 1'b0;
`endif

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_fs_d;
    logic                   w_fs;
    logic                   w_rise;
    logic                   w_fall;

    state_t                 r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       r_high_hold;
    logic                   r_busy;
    logic                   r_valid;
    logic                   r_timeout;
    logic [CNT_W-1:0]       r_period;
    logic [CNT_W-1:0]       r_high_time;

    assign w_fs   = r_sync[SYNC_STAGES-1];
    assign w_rise =  w_fs & ~r_fs_d;
    assign w_fall = ~w_fs &  r_fs_d;

    // Synchronize fin and keep one extra delayed copy for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
            r_fs_d <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], fin};
            r_fs_d <= w_fs;
        end
    end

    // Measurement FSM: ARM waits for the opening rise, MEASURE counts to the
    // closing rise capturing the falling-edge count on the way.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_rst_state;
            r_cnt       <= c_zero;
            r_high_hold <= c_zero;
            r_busy      <= c_rst_busy;
            r_valid     <= 1'b0;
            r_timeout   <= 1'b0;
            r_period    <= c_zero;
            r_high_time <= c_zero;
        end else begin
            r_valid   <= 1'b0;
            r_timeout <= 1'b0;
            case (r_state)
                ST_IDLE: begin
`ifdef CONTINUOUS_MEAS_EN
                    r_state <= ST_ARM;
                    r_cnt   <= c_zero;
                    r_busy  <= 1'b1;
`else
                    if (start) begin
                        r_state <= ST_ARM;
                        r_cnt   <= c_zero;
                        r_busy  <= 1'b1;
                    end
`endif
                end
                ST_ARM: begin
                    if (w_rise) begin
                        r_state     <= ST_MEASURE;
                        r_cnt       <= c_one;
                        r_high_hold <= c_zero;
                    end else if (r_cnt == c_timeout) begin
                        r_timeout <= 1'b1;
`ifdef CONTINUOUS_MEAS_EN
                        r_cnt     <= c_zero;
`else
                        r_state   <= ST_IDLE;
                        r_busy    <= 1'b0;
`endif
                    end else begin
                        r_cnt <= r_cnt + c_one;
                    end
                end
                ST_MEASURE: begin
                    // A closing rise wins over a coincident timeout.
                    if (w_rise) begin
                        r_valid     <= 1'b1;
                        r_period    <= r_cnt;
                        r_high_time <= r_high_hold;
`ifdef CONTINUOUS_MEAS_EN
                        r_cnt       <= c_one;
                        r_high_hold <= c_zero;
`else
                        r_state     <= ST_IDLE;
                        r_busy      <= 1'b0;
`endif
                    end else begin
                        if (w_fall) begin
                            r_high_hold <= r_cnt;
                        end
                        if (r_cnt == c_timeout) begin
                            r_timeout <= 1'b1;
`ifdef CONTINUOUS_MEAS_EN
                            r_state   <= ST_ARM;
                            r_cnt     <= c_zero;
`else
                            r_state   <= ST_IDLE;
                            r_busy    <= 1'b0;
`endif
                        end else begin
                            r_cnt <= r_cnt + c_one;
                        end
                    end
                end
                default: begin
                    r_state <= c_rst_state;
                    r_busy  <= c_rst_busy;
                    r_cnt   <= c_zero;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign valid     = r_valid;
    assign timeout   = r_timeout;
    assign period    = r_period;
    assign high_time = r_high_time;

endmodule
`default_nettype wire
